// File: rtl/lcd_mmio_port.sv
// Memory-mapped character-LCD port: CPU stores feed a FIFO that a strobe FSM drains onto the LCD bus.
// Define LCD_SIM_PRINT_EN to echo each completed data byte to the simulator console with $write.
module lcd_mmio_port #(
    parameter int BUS_MODE     = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wenable,
    output logic [31:0] rdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_enable,
    output logic        busy
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int MAXC  = (SETUP_CYCLES > PULSE_CYCLES) ?
                           ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                           ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int CNT_W = $clog2(MAXC) + 1;

    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    // FIFO storage: bit 8 is rs, bits 7:0 the byte
    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_nib;
    logic [7:0]       r_shift;
    logic [7:0]       r_lcd_data;
    logic             r_rs;
    logic             r_en;
    logic             w_en_nx;
    logic             r_busy;

    logic             w_wr;
    logic             w_push_req;
    logic             w_ctrl;
    logic             w_flush;
    logic             w_clr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_ovf_set;
    logic             w_can_pop;
    logic             w_pop;
    logic             w_load;
    logic             w_nib2;
    logic [8:0]       w_head;
    logic [CW-1:0]    w_count_nx;
    logic [7:0]       w_cnt8;
    logic [31:0]      w_status;
    logic             w_unused;

    assign w_wr       = sel & wenable[0];
    assign w_push_req = w_wr & ((addr == 2'd0) | (addr == 2'd1));
    assign w_ctrl     = w_wr & (addr == 2'd3);
    assign w_flush    = w_ctrl & wdata[1];
    assign w_clr      = w_ctrl & wdata[0];
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push
    assign w_push     = w_push_req & ~w_full & ~w_flush;
    assign w_ovf_set  = w_push_req & w_full & ~w_flush;
    assign w_can_pop  = ~w_empty & ~w_flush;
    assign w_head     = r_mem[r_rptr];

    assign w_unused   = ^{wdata[31:8], wenable[3:1], r_shift[7:4]};

    always_comb begin
        w_count_nx = r_count;
        if (w_flush) begin
            w_count_nx = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nx = r_count + 1'b1;
                2'b01:   w_count_nx = r_count - 1'b1;
                default: w_count_nx = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nx;
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
            if (w_clr)
                r_ovf <= 1'b0;
            else if (w_ovf_set)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {(addr == 2'd0), wdata[7:0]};
    end

    // Strobe sequencer: next state and strobe/pop controls
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_en_nx    = 1'b0;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_nib2     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_can_pop) begin
                    w_pop      = 1'b1;
                    w_load     = 1'b1;
                    w_state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_END) begin
                    w_cnt_nx   = '0;
                    w_en_nx    = 1'b1;
                    w_state_nx = S_PULSE;
                end
            end
            S_PULSE: begin
                w_en_nx = 1'b1;
                if (r_cnt == PULSE_END) begin
                    w_cnt_nx   = '0;
                    w_en_nx    = 1'b0;
                    w_state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_END) begin
                    w_cnt_nx = '0;
                    if ((BUS_MODE == 4) && !r_nib) begin
                        w_nib2     = 1'b1;
                        w_state_nx = S_SETUP;
                    end else if (w_can_pop) begin
                        w_pop      = 1'b1;
                        w_load     = 1'b1;
                        w_state_nx = S_SETUP;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_nib      <= 1'b0;
            r_shift    <= '0;
            r_lcd_data <= '0;
            r_rs       <= 1'b0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_en    <= w_en_nx;
            r_busy  <= (w_state_nx != S_IDLE) | (w_count_nx != '0);
            if (w_load) begin
                r_shift    <= w_head[7:0];
                r_rs       <= w_head[8];
                r_nib      <= 1'b0;
                r_lcd_data <= (BUS_MODE == 4) ? {w_head[7:4], 4'h0} : w_head[7:0];
            end else if (w_nib2) begin
                r_nib      <= 1'b1;
                r_lcd_data <= {r_shift[3:0], 4'h0};
            end
        end
    end

`ifdef LCD_SIM_PRINT_EN
    // Fires on the edge where enable falls for the last (or only) strobe of a data byte
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == S_PULSE) && (r_cnt == PULSE_END) && r_rs &&
            ((BUS_MODE != 4) || r_nib))
            $write("%c", r_shift);
    end
`else
    // Console echo is compiled out; hardware behaviour is unchanged.
`endif

    assign w_cnt8   = 8'(r_count);
    assign w_status = {16'h0, w_cnt8, 4'h0, r_ovf, w_empty, w_full, r_busy};

    always_comb begin
        rdata = '0;
        if (addr == 2'd2)
            rdata = w_status;
    end

    assign lcd_data   = r_lcd_data;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_enable = r_en;
    assign busy       = r_busy;

endmodule

// File: doc/lcd_mmio_port.md
# lcd_mmio_port

Memory-mapped character-LCD port that replaces the ad-hoc data/ctrl/enable register trio in the top level. CPU stores enqueue data or command bytes into a FIFO. A transfer FSM then drains the FIFO and generates the LCD enable strobe in hardware with parametrised setup, pulse and hold timing, in 8-bit or 4-bit (nibble) bus mode. It sits on the CPU data port beside `dual_memory`, selected by the top-level address decode (`data_addr[31]`).

## Interface
- `BUS_MODE`, 8: LCD bus width; 8 or 4 only.
- `FIFO_DEPTH`, 8: entries; power of 2, ≥2.
- `SETUP_CYCLES`, 2: rs/data stable before enable rises; ≥1.
- `PULSE_CYCLES`, 4: enable high time; ≥1.
- `HOLD_CYCLES`, 2: rs/data held after enable falls; ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sel` in 1: peripheral selected (address decode).
- `addr` in 2: word offset (`data_addr[3:2]`).
- `wdata` in 32: store data.
- `wenable` in 4: byte enables; only bit 0 is used.
- `rdata` out 32: register readback, combinational.
- `lcd_data` out 8: LCD data bus.
- `lcd_rs` out 1: register select (1 = data, 0 = command).
- `lcd_rw` out 1: tied 0 (write-only).
- `lcd_enable` out 1: enable strobe.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- A write fires when `sel & wenable[0]` is true.
- Register map:
  - 0 DATA: write pushes `{rs=1, wdata[7:0]}`.
  - 1 CMD: write pushes `{rs=0, wdata[7:0]}`.
  - 2 STATUS: read-only.
  - 3 CTRL: write bit0=1 clears the overflow flag; bit1=1 flushes the FIFO.
- STATUS bit layout:
  - bit0: busy
  - bit1: full
  - bit2: empty
  - bit3: sticky overflow
  - bits[15:8]: FIFO count
  - all other bits 0
- `rdata` returns STATUS at addr 2 and 0 otherwise, independent of `sel`.
- Full is evaluated on the pre-edge count. A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged.
- Flush empties the FIFO at the edge. An in-flight transfer still completes. A push in the same cycle as flush is discarded.
- Clear and flush in one CTRL write both take effect.
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - IDLE→SETUP when the FIFO is non-empty. The head entry is popped into a shift register and `lcd_rs`/`lcd_data` are driven.
  - SETUP holds `lcd_enable`=0 for SETUP_CYCLES, then goes to PULSE.
  - PULSE holds `lcd_enable`=1 for PULSE_CYCLES, then goes to HOLD.
  - HOLD holds `lcd_enable`=0 for HOLD_CYCLES. It then goes to SETUP for the second nibble (4-bit mode, first half done). Otherwise it goes to SETUP with a new pop if the FIFO is non-empty, or to IDLE.
- 8-bit mode: `lcd_data` = byte.
- 4-bit mode: high nibble first on `lcd_data[7:4]`, then low nibble; `lcd_data[3:0]` = 0.
- `lcd_rs` stays constant across both nibbles.
- `lcd_data`/`lcd_rs` hold their last value in IDLE.
- Wrap-around: read/write pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - `lcd_data`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_enable`=0, `busy`=0.
  - FIFO empty, overflow=0, FSM IDLE.
- Asserting reset mid-transfer aborts immediately: `lcd_enable` drops asynchronously.
- All LCD outputs are registered.
- Write at edge N (FIFO empty, IDLE): count=1 after N. Pop and SETUP at edge N+1. `lcd_enable` rises at edge N+1+SETUP_CYCLES.
- One transfer unit = SETUP+PULSE+HOLD cycles: 8 by default. A 4-bit-mode byte takes 16.
- Back-to-back entries have no IDLE gap: the next SETUP begins the edge after the final HOLD cycle.
- `busy` is registered and reflects state after each edge.

## Configuration
- `LCD_SIM_PRINT_EN`: defined → on each completed data-byte transfer (`lcd_rs`=1, final falling `lcd_enable` edge of the byte), `$write("%c", byte)`.
- In 4-bit mode the printed byte is the reassembled pair.
- Commands are never printed.
- Undefined → no simulation-only constructs are compiled; RTL behaviour is identical.

## Test plan
- Reset, then write DATA 0x41 → `lcd_rs`=1, `lcd_data`=0x41. `lcd_enable` is high exactly 4 cycles, rising 2 cycles after SETUP entry. `busy` falls 8 cycles after pop. With `LCD_SIM_PRINT_EN`, prints "A".
- BUS_MODE=4, write CMD 0x28 → two strobes, `lcd_data`=0x20 then 0x80. `lcd_rs`=0 throughout. Total 16 cycles.
- Write 10 bytes 0x30–0x39 back-to-back while FSM is busy (depth 8) → 9 accepted: 1 popped plus 8 queued. STATUS bit3=1. The last byte 0x39 is dropped. Strobes are contiguous with no IDLE cycles.
- With 5 queued, write CTRL=0x3 during PULSE → current strobe completes. STATUS reads count=0, overflow=0, empty=1 afterwards. No further strobes.
- Assert `rst_n`=0 mid-PULSE → `lcd_enable` drops without waiting for a clock. All outputs reach reset values. STATUS reads 0x4 after release.
- Write to addr 2 and a write with `sel`=0 → no FIFO change; count stays 0.
